// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, next-state function and IR constants.
// The state encoding is also used by the JTAG master.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  localparam logic [1:0] IR_CAPTURE = 2'b01;
  localparam logic [9:0] IR_BYPASS  = 10'h3FF;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TEST_LOGIC_RESET: tap_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    tap_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        tap_next = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       tap_next = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         tap_next = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         tap_next = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         tap_next = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         tap_next = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        tap_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        tap_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       tap_next = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         tap_next = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         tap_next = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         tap_next = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         tap_next = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        tap_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          tap_next = TEST_LOGIC_RESET;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_target_if.sv
// Data FIFO link of the TAP target: TX FIFO read side and RX FIFO write side.
// slave = TAP target, master = FIFO pair.
interface jtag_tap_target_if #(
  parameter int DATA_FIFO = 8
);
  logic [DATA_FIFO-1:0] rdata_data;
  logic                 rd_data;
  logic                 empty_data;
  logic [DATA_FIFO-1:0] wdata_data;
  logic                 wr_data;
  logic                 full_data;

  modport slave (
    input  rdata_data, empty_data, full_data,
    output rd_data, wdata_data, wr_data
  );

  modport master (
    output rdata_data, empty_data, full_data,
    input  rd_data, wdata_data, wr_data
  );
endinterface

// File: rtl/jtag_sync.sv
// Brings tck/tms/tdi into the clk domain; tck also yields 1-clk rise/fall pulses.
module jtag_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [SYNC_STAGES-1:0] tck_sr;
  logic [SYNC_STAGES-1:0] tms_sr;
  logic [SYNC_STAGES-1:0] tdi_sr;
  logic                   tck_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_sr <= '0;
      tms_sr <= '0;
      tdi_sr <= '0;
      tck_q  <= 1'b0;
    end else begin
      tck_sr <= {tck_sr[SYNC_STAGES-2:0], tck};
      tms_sr <= {tms_sr[SYNC_STAGES-2:0], tms};
      tdi_sr <= {tdi_sr[SYNC_STAGES-2:0], tdi};
      tck_q  <= tck_sr[SYNC_STAGES-1];
    end
  end

  assign tck_rise = tck_sr[SYNC_STAGES-1] & ~tck_q;
  assign tck_fall = ~tck_sr[SYNC_STAGES-1] & tck_q;
  assign tms_s    = tms_sr[SYNC_STAGES-1];
  assign tdi_s    = tdi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_target.sv
// Target-side JTAG TAP running on clk: oversampled tck, 1149.1 FSM, IR/DR shift, tdo.
// DR words come from the TX FIFO at Capture-DR and go to the RX FIFO at Update-DR.
//
// state            | meaning
// TEST_LOGIC_RESET | idle after reset, IR forced to BYPASS
// RUN_TEST_IDLE    | idle between scans
// SELECT_DR/IR     | choosing DR or IR path
// CAPTURE_DR       | leaving: load dr_shift from TX FIFO (or clear byp)
// SHIFT_DR         | leaving: shift tdi into dr_shift/byp
// EXIT1/2, PAUSE   | hold shift contents
// UPDATE_DR        | entering: push dr_shift to RX FIFO
// CAPTURE_IR       | leaving: load 2'b01 pattern
// SHIFT_IR         | leaving: shift tdi into ir_shift
// UPDATE_IR        | entering: ir_value <= ir_shift
module jtag_tap_target
  import jtag_pkg::*;
#(
  parameter int DATA_INSTRUCTION = 10,
  parameter int DATA_FIFO        = 8,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tck,
  input  logic                        tms,
  input  logic                        tdi,
  output logic                        tdo,
  output logic [DATA_INSTRUCTION-1:0] ir_value,
  output logic                        ir_update,
  output tap_state_t                  tap_state,
  jtag_tap_target_if.slave            fifo,
  output logic                        overflow
);

  logic tck_rise;
  logic tck_fall;
  logic tms_s;
  logic tdi_s;

  tap_state_t                  state;
  tap_state_t                  state_nxt;
  logic [DATA_INSTRUCTION-1:0] ir_shift;
  logic [DATA_FIFO-1:0]        dr_shift;
  logic                        byp;
  logic                        bypass;

  jtag_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  assign bypass    = &ir_value;
  assign state_nxt = tap_next(state, tms_s);
  assign tap_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= TEST_LOGIC_RESET;
      ir_shift        <= '0;
      ir_value        <= '1;
      ir_update       <= 1'b0;
      dr_shift        <= '0;
      byp             <= 1'b0;
      tdo             <= 1'b0;
      overflow        <= 1'b0;
      fifo.rd_data    <= 1'b0;
      fifo.wr_data    <= 1'b0;
      fifo.wdata_data <= '0;
    end else begin
      ir_update    <= 1'b0;
      fifo.rd_data <= 1'b0;
      fifo.wr_data <= 1'b0;

      if (tck_rise) begin
        state <= state_nxt;

        // actions belong to the state being left
        case (state)
          CAPTURE_IR: ir_shift <= DATA_INSTRUCTION'(IR_CAPTURE);
          SHIFT_IR:   ir_shift <= {tdi_s, ir_shift[DATA_INSTRUCTION-1:1]};
          CAPTURE_DR: begin
            if (bypass) begin
              byp <= 1'b0;
            end else begin
              dr_shift     <= fifo.empty_data ? '0 : fifo.rdata_data;
              fifo.rd_data <= ~fifo.empty_data;
            end
          end
          SHIFT_DR: begin
            if (bypass) byp <= tdi_s;
            else        dr_shift <= {tdi_s, dr_shift[DATA_FIFO-1:1]};
          end
          default: ;
        endcase

        if (state_nxt == UPDATE_IR) begin
          ir_value  <= ir_shift;
          ir_update <= 1'b1;
        end

        if (state_nxt == UPDATE_DR && !bypass) begin
          fifo.wdata_data <= dr_shift;
          if (fifo.full_data) overflow     <= 1'b1;
          else                fifo.wr_data <= 1'b1;
        end

        if (state_nxt == TEST_LOGIC_RESET) begin
          ir_value <= '1;
          overflow <= 1'b0;
        end
      end

      if (tck_fall) begin
        if (state == SHIFT_IR)      tdo <= ir_shift[0];
        else if (state == SHIFT_DR) tdo <= bypass ? byp : dr_shift[0];
      end
    end
  end

endmodule
